// File: rtl/sync_barcode_gen_if.sv
// Seconds-stream handshake between the frame-to-seconds counter and the barcode generator.
interface sync_barcode_gen_if;
    logic        sec_tvalid;
    logic        sec_tready;
    logic [15:0] sec_tdata;

    modport master (output sec_tvalid, output sec_tdata, input sec_tready);
    modport slave  (input sec_tvalid, input sec_tdata, output sec_tready);
endinterface

// File: rtl/sync_barcode_gen.sv
// Serialises each accepted seconds value as a pulse-width-coded barcode on sync_pulse.
// Optional macro SYNC_PARITY_EN appends an even-parity slot after the data bits.
module sync_barcode_gen #(
    parameter int unsigned UNIT     = 100000,
    parameter int unsigned NBITS    = 12,
    parameter int unsigned START_MS = 100,
    parameter int unsigned GAP_MS   = 50,
    parameter int unsigned SLOT_MS  = 60,
    parameter int unsigned ONE_MS   = 40,
    parameter int unsigned ZERO_MS  = 20
) (
    input  logic                clk,
    input  logic                rst,
    sync_barcode_gen_if.slave   sec,
    output logic                sync_pulse,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          drop_cnt
);

`ifdef SYNC_PARITY_EN
    localparam int unsigned SR_W = NBITS + 1;
`else
    localparam int unsigned SR_W = NBITS;
`endif

    localparam logic [31:0] START_CYC = 32'(START_MS * UNIT - 1);
    localparam logic [31:0] GAP_CYC   = 32'(GAP_MS * UNIT - 1);
    localparam logic [31:0] ONE_HI    = 32'(ONE_MS * UNIT - 1);
    localparam logic [31:0] ZERO_HI   = 32'(ZERO_MS * UNIT - 1);
    localparam logic [31:0] ONE_LO    = 32'((SLOT_MS - ONE_MS) * UNIT - 1);
    localparam logic [31:0] ZERO_LO   = 32'((SLOT_MS - ZERO_MS) * UNIT - 1);
    localparam logic [4:0]  LAST_IDX  = 5'(SR_W - 1);

    typedef enum logic [2:0] {IDLE, START_HI, START_LO, BIT_HI, BIT_LO, DONE} state_t;

    state_t            state, state_nx;
    logic [31:0]       timer, timer_nx;
    logic [SR_W-1:0]   sr, sr_nx, sr_load, sr_shift;
    logic [4:0]        bit_idx, idx_nx;
    logic              accept;

    assign sec.sec_tready = (state == IDLE) && !rst;
    assign accept         = sec.sec_tvalid && sec.sec_tready;
    assign sr_shift       = sr << 1;

`ifdef SYNC_PARITY_EN
    logic [NBITS-1:0] data_bits;
    assign data_bits = NBITS'(sec.sec_tdata);
    assign sr_load   = {data_bits, ^data_bits};
`else
    assign sr_load   = SR_W'(sec.sec_tdata);
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        sr_nx    = sr;
        idx_nx   = bit_idx;
        case (state)
            IDLE: if (accept) begin
                state_nx = START_HI;
                timer_nx = START_CYC;
                sr_nx    = sr_load;
                idx_nx   = '0;
            end
            START_HI: if (timer == '0) begin
                state_nx = START_LO;
                timer_nx = GAP_CYC;
            end else timer_nx = timer - 32'd1;
            START_LO: if (timer == '0) begin
                state_nx = BIT_HI;
                timer_nx = sr[SR_W-1] ? ONE_HI : ZERO_HI;
            end else timer_nx = timer - 32'd1;
            // Low time complements the high time of the same bit, so the shift waits for BIT_LO to end.
            BIT_HI: if (timer == '0) begin
                state_nx = BIT_LO;
                timer_nx = sr[SR_W-1] ? ONE_LO : ZERO_LO;
            end else timer_nx = timer - 32'd1;
            BIT_LO: if (timer == '0) begin
                if (bit_idx == LAST_IDX) begin
                    state_nx = DONE;
                    timer_nx = '0;
                end else begin
                    state_nx = BIT_HI;
                    sr_nx    = sr_shift;
                    idx_nx   = bit_idx + 5'd1;
                    timer_nx = sr_shift[SR_W-1] ? ONE_HI : ZERO_HI;
                end
            end else timer_nx = timer - 32'd1;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: all state here is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            sr         <= '0;
            bit_idx    <= '0;
            sync_pulse <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            sr         <= sr_nx;
            bit_idx    <= idx_nx;
            sync_pulse <= (state_nx == START_HI) || (state_nx == BIT_HI);
            busy       <= (state_nx != IDLE);
            frame_done <= (state_nx == DONE);
            if (sec.sec_tvalid && !sec.sec_tready && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_sync_barcode_gen.sv
// Directed bench for sync_barcode_gen at UNIT=10: table of frames plus reset/drop corner sequences.
module tb_sync_barcode_gen;

`ifdef SYNC_PARITY_EN
    localparam int SLOTS = 13;
`else
    localparam int SLOTS = 12;
`endif
    localparam int FRAME_LEN = 1500 + SLOTS * 600;
    localparam int BUDGET    = 12000;

    typedef struct {
        logic [15:0] tdata;
        logic [11:0] exp_code;
        logic        exp_par;
        int          inject_at;
        logic [7:0]  exp_drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync_pulse, busy, frame_done;
    logic [7:0] drop_cnt;
    logic       wave [0:BUDGET-1];
    int         n_checks = 0;
    int         n_errors = 0;
    vec_t       vecs [5];

    sync_barcode_gen_if sec_if ();

    sync_barcode_gen #(.UNIT(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .sec        (sec_if),
        .sync_pulse (sync_pulse),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_level(input logic [15:0] slots, input int i);
        int j, s, off;
        logic b;
        if (i < 1000) return 1'b1;
        if (i < 1500) return 1'b0;
        j   = i - 1500;
        s   = j / 600;
        off = j % 600;
        b   = slots[SLOTS-1-s];
        return off < (b ? 400 : 200);
    endfunction

    // Accepts v.tdata, records sync_pulse until frame_done, and ends in the first ready cycle.
    task automatic run_frame(input vec_t v);
        int          i, done_at, mism, first_bad;
        logic [15:0] exp_slots, got_slots;
`ifdef SYNC_PARITY_EN
        exp_slots = {3'b000, v.exp_code, v.exp_par};
`else
        exp_slots = {4'b0000, v.exp_code};
`endif
        check("ready_before_accept", 32'(sec_if.sec_tready), 32'd1);
        sec_if.sec_tvalid = 1'b1;
        sec_if.sec_tdata  = v.tdata;
        tick;
        sec_if.sec_tvalid = 1'b0;
        check("latency_pulse", 32'(sync_pulse), 32'd1);
        i       = 0;
        done_at = -1;
        while (i < BUDGET) begin
            wave[i] = sync_pulse;
            if (frame_done) begin
                done_at = i;
                break;
            end
            if (i == v.inject_at) begin
                sec_if.sec_tvalid = 1'b1;
                sec_if.sec_tdata  = 16'h0FFF;
            end else begin
                sec_if.sec_tvalid = 1'b0;
            end
            tick;
            i++;
        end
        sec_if.sec_tvalid = 1'b0;
        check("frame_done_at", 32'(done_at), 32'(FRAME_LEN));
        mism      = 0;
        first_bad = -1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (wave[k] !== exp_level(exp_slots, k)) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
        end
        if (mism != 0) $display("first bad sample at offset %0d", first_bad);
        check("wave_mismatches", 32'(mism), 32'd0);
        got_slots = '0;
        for (int s = 0; s < SLOTS; s++)
            got_slots = {got_slots[14:0], wave[1500 + s * 600 + 300]};
        check("decoded_slots", 32'(got_slots), 32'(exp_slots));
        check("done_pulse_low", 32'(sync_pulse), 32'd0);
        check("ready_in_done", 32'(sec_if.sec_tready), 32'd0);
        tick;
        check("done_one_cycle", 32'(frame_done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("ready_after_done", 32'(sec_if.sec_tready), 32'd1);
        check("drop_cnt", 32'(drop_cnt), 32'(v.exp_drop));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        vec_t v;
        int   k;

        vecs[0] = '{16'h0005, 12'h005, 1'b0, 4999, 8'd1};
        vecs[1] = '{16'h0FFF, 12'hFFF, 1'b0, -1,   8'd1};
        vecs[2] = '{16'h0000, 12'h000, 1'b0, -1,   8'd1};
        vecs[3] = '{16'hFA5A, 12'hA5A, 1'b0, -1,   8'd1};
        vecs[4] = '{16'h0007, 12'h007, 1'b1, -1,   8'd1};

        // Reset held with tvalid asserted: nothing accepted, nothing counted.
        rst               = 1'b1;
        sec_if.sec_tvalid = 1'b1;
        sec_if.sec_tdata  = 16'h0123;
        repeat (3) begin
            tick;
            check("rst_pulse", 32'(sync_pulse), 32'd0);
            check("rst_ready", 32'(sec_if.sec_tready), 32'd0);
            check("rst_drop", 32'(drop_cnt), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        rst               = 1'b0;
        sec_if.sec_tvalid = 1'b0;
        #1;
        check("ready_after_rst", 32'(sec_if.sec_tready), 32'd1);

        // Back-to-back frames: each accept lands in the first ready cycle after DONE.
        for (int n = 0; n < 5; n++) run_frame(vecs[n]);

        // Saturation: 300 offers while busy on top of the earlier drop.
        sec_if.sec_tvalid = 1'b1;
        sec_if.sec_tdata  = 16'h0FFF;
        tick;
        check("sat_accept_busy", 32'(busy), 32'd1);
        repeat (300) tick;
        sec_if.sec_tvalid = 1'b0;
        check("drop_saturated", 32'(drop_cnt), 32'd255);
        k = 0;
        while (!frame_done && k < BUDGET) begin
            tick;
            k++;
        end
        check("sat_frame_done", 32'(frame_done), 32'd1);
        tick;
        check("drop_still_255", 32'(drop_cnt), 32'd255);
        check("sat_ready_back", 32'(sec_if.sec_tready), 32'd1);

        // Abort during the 5th bit's high time (bit 7 of 0x005 is 0: high at offsets 3900..4099).
        sec_if.sec_tvalid = 1'b1;
        sec_if.sec_tdata  = 16'h0005;
        tick;
        sec_if.sec_tvalid = 1'b0;
        repeat (3950) tick;
        check("pre_abort_pulse", 32'(sync_pulse), 32'd1);
        rst = 1'b1;
        tick;
        check("abort_pulse", 32'(sync_pulse), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (5000) begin
            tick;
            if (frame_done || sync_pulse) seen = 1'b1;
        end
        check("no_activity_after_abort", 32'(seen), 32'd0);
        check("abort_drop_cleared", 32'(drop_cnt), 32'd0);
        v = '{16'h0005, 12'h005, 1'b0, -1, 8'd0};
        run_frame(v);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
